// File: rtl/a2d_spi_resp.sv
// SPI responder modelling an eight-channel 12-bit A2D: decodes 16-bit commands, returns the snapshot next frame.
// Optional sticky framing-error output enabled by defining A2D_RESP_FRMERR_EN.
module a2d_spi_resp #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             SS_n,
   input  logic             SCLK,
   input  logic             MOSI,
   output logic             MISO,
   input  logic [95:0]      analog_in,
   output logic             cmd_vld,
   output logic [2:0]       cmd_chnnl,
   output logic             busy,
   output logic [CNT_W-1:0] xfer_cnt
`ifdef A2D_RESP_FRMERR_EN
   ,
   output logic             frm_err
`endif
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] fill_q, fill_d;
   logic                   ss_prev_q, ss_prev_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   armed_q, armed_d;
   logic [15:0]            tx_shift_q, tx_shift_d;
   logic [13:0]            rx_shift_q, rx_shift_d;
   logic [4:0]             bit_cnt_q, bit_cnt_d;
   logic [11:0]            result_q, result_d;
   logic [2:0]             cmd_chnnl_q, cmd_chnnl_d;
   logic                   cmd_vld_q, cmd_vld_d;
   logic [CNT_W-1:0]       xfer_cnt_q, xfer_cnt_d;
`ifdef A2D_RESP_FRMERR_EN
   logic                   frm_err_q, frm_err_d;
`endif

   logic       ss_s, sclk_s, mosi_s;
   logic       ss_fall, ss_rise, sclk_rise, sclk_fall;
   logic [6:0] sel_base;

   always_comb begin
      ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
      ss_s        = ss_sync_q[SYNC_STAGES-1];
      sclk_s      = sclk_sync_q[SYNC_STAGES-1];
      mosi_s      = mosi_sync_q[SYNC_STAGES-1];
      ss_prev_d   = ss_s;
      sclk_prev_d = sclk_s;
      // A frame already in flight at reset release is ignored until SS_n is genuinely seen high.
      armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & ss_s);
      ss_fall     = armed_q & ss_prev_q & ~ss_s;
      ss_rise     = ~ss_prev_q & ss_s;
      sclk_rise   = ~sclk_prev_q & sclk_s;
      sclk_fall   = sclk_prev_q & ~sclk_s;
   end

   always_comb begin
      state_d     = state_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      bit_cnt_d   = bit_cnt_q;
      result_d    = result_q;
      cmd_chnnl_d = cmd_chnnl_q;
      cmd_vld_d   = 1'b0;
      xfer_cnt_d  = xfer_cnt_q;
`ifdef A2D_RESP_FRMERR_EN
      frm_err_d   = frm_err_q;
`endif
      busy        = 1'b0;
      MISO        = 1'b0;
      sel_base    = 7'(rx_shift_q[13:11]) * 7'd12;
      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               tx_shift_d = {4'h0, result_q};
               bit_cnt_d  = 5'd0;
               state_d    = ACTIVE;
            end
         end
         ACTIVE: begin
            busy = 1'b1;
            MISO = tx_shift_q[15];
            // Frame close wins over any coincident SCLK edge.
            if (ss_rise) begin
               state_d = IDLE;
               if (bit_cnt_q == 5'd16) begin
                  cmd_chnnl_d = rx_shift_q[13:11];
                  result_d    = analog_in[sel_base +: 12];
                  cmd_vld_d   = 1'b1;
                  xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
               end
`ifdef A2D_RESP_FRMERR_EN
               else begin
                  frm_err_d = 1'b1;
               end
`endif
            end else begin
               if (sclk_rise) begin
                  rx_shift_d = {rx_shift_q[12:0], mosi_s};
                  if (bit_cnt_q != 5'd31) begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end
               if (sclk_fall && (bit_cnt_q != 5'd0)) begin
                  tx_shift_d = {tx_shift_q[14:0], 1'b0};
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ss_sync_q   <= '1;
         sclk_sync_q <= '1;
         mosi_sync_q <= '0;
         fill_q      <= '0;
         ss_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b1;
         armed_q     <= 1'b0;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         bit_cnt_q   <= '0;
         result_q    <= '0;
         cmd_chnnl_q <= '0;
         cmd_vld_q   <= 1'b0;
         xfer_cnt_q  <= '0;
`ifdef A2D_RESP_FRMERR_EN
         frm_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ss_sync_q   <= ss_sync_d;
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         fill_q      <= fill_d;
         ss_prev_q   <= ss_prev_d;
         sclk_prev_q <= sclk_prev_d;
         armed_q     <= armed_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         bit_cnt_q   <= bit_cnt_d;
         result_q    <= result_d;
         cmd_chnnl_q <= cmd_chnnl_d;
         cmd_vld_q   <= cmd_vld_d;
         xfer_cnt_q  <= xfer_cnt_d;
`ifdef A2D_RESP_FRMERR_EN
         frm_err_q   <= frm_err_d;
`endif
      end
   end

   assign cmd_vld   = cmd_vld_q;
   assign cmd_chnnl = cmd_chnnl_q;
   assign xfer_cnt  = xfer_cnt_q;
`ifdef A2D_RESP_FRMERR_EN
   assign frm_err   = frm_err_q;
`endif

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: frames driven at SCLK = clk/32, responses compared to hand-computed values.
module tb_a2d_spi_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic [95:0] analog_in;
   logic        cmd_vld;
   logic [2:0]  cmd_chnnl;
   logic        busy;
   logic [15:0] xfer_cnt;
`ifdef A2D_RESP_FRMERR_EN
   logic        frm_err;
`endif

   int total = 0;
   int bad   = 0;
   int vld_cnt = 0;

   logic        snap_busy_mid;
   logic        snap_busy_end;
   logic        snap_rst_busy;
   logic        snap_rst_miso;
   logic        snap_rst_vld;
   logic [2:0]  snap_rst_chnnl;
   logic [15:0] snap_rst_xfer;

   a2d_spi_resp #(.SYNC_STAGES(2), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .SS_n      (SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .analog_in (analog_in),
      .cmd_vld   (cmd_vld),
      .cmd_chnnl (cmd_chnnl),
      .busy      (busy),
      .xfer_cnt  (xfer_cnt)
`ifdef A2D_RESP_FRMERR_EN
      ,
      .frm_err   (frm_err)
`endif
   );

   always #5 clk = ~clk;

   // Each cycle that cmd_vld is high bumps the count, so a single-cycle pulse adds exactly one.
   always @(negedge clk) begin
      if (cmd_vld === 1'b1) vld_cnt++;
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   // Drives one frame of nbits SCLK cycles; rst_at>0 pulses rst for one clk right after that SCLK rise.
   task automatic applyStimulus(input logic [15:0] cmd, input int nbits, input int rst_at,
                                output logic [15:0] rx_word);
      rx_word = 16'h0000;
      @(negedge clk);
      SS_n = 1'b0;
      repeat (16) @(negedge clk);
      snap_busy_mid = busy;
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = cmd[15-i];
         repeat (16) @(negedge clk);
         rx_word = {rx_word[14:0], MISO};
         SCLK = 1'b1;
         if (i + 1 == rst_at) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            snap_rst_busy  = busy;
            snap_rst_miso  = MISO;
            snap_rst_vld   = cmd_vld;
            snap_rst_chnnl = cmd_chnnl;
            snap_rst_xfer  = xfer_cnt;
            repeat (14) @(negedge clk);
         end else begin
            repeat (16) @(negedge clk);
         end
      end
      snap_busy_end = busy;
      SS_n = 1'b1;
      repeat (24) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0h exp=0", busy); end
      total++; if (MISO !== 1'b0) begin bad++; $display("[TB] FAIL reset_miso got=%0h exp=0", MISO); end
      total++; if (cmd_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_vld got=%0h exp=0", cmd_vld); end
      total++; if (cmd_chnnl !== 3'd0) begin bad++; $display("[TB] FAIL reset_chnnl got=%0h exp=0", cmd_chnnl); end
      total++; if (xfer_cnt !== 16'h0000) begin bad++; $display("[TB] FAIL reset_xfer got=%0h exp=0", xfer_cnt); end
`ifdef A2D_RESP_FRMERR_EN
      total++; if (frm_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_frmerr got=%0h exp=0", frm_err); end
`endif
   endtask

   task automatic test_good_frame();
      logic [15:0] w;
      int v0;
      do_reset();
      analog_in = '0;
      analog_in[47:36] = 12'hA5C;
      v0 = vld_cnt;
      applyStimulus(16'h1800, 16, 0, w);
      total++; if (w !== 16'h0000) begin bad++; $display("[TB] FAIL good_first_resp got=%0h exp=0000", w); end
      total++; if (snap_busy_mid !== 1'b1) begin bad++; $display("[TB] FAIL good_busy_mid got=%0h exp=1", snap_busy_mid); end
      total++; if (vld_cnt - v0 != 1) begin bad++; $display("[TB] FAIL good_vld_pulses got=%0d exp=1", vld_cnt - v0); end
      total++; if (cmd_chnnl !== 3'd3) begin bad++; $display("[TB] FAIL good_chnnl got=%0h exp=3", cmd_chnnl); end
      total++; if (xfer_cnt !== 16'd1) begin bad++; $display("[TB] FAIL good_xfer got=%0h exp=1", xfer_cnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL good_busy_after got=%0h exp=0", busy); end
      applyStimulus(16'h0000, 16, 0, w);
      total++; if (w !== 16'h0A5C) begin bad++; $display("[TB] FAIL good_second_resp got=%0h exp=0a5c", w); end
      total++; if (xfer_cnt !== 16'd2) begin bad++; $display("[TB] FAIL good_xfer2 got=%0h exp=2", xfer_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_resp [9] = '{16'h0000, 16'h0000, 16'h0101, 16'h0202, 16'h0303,
                                    16'h0404, 16'h0505, 16'h0606, 16'h0707};
      logic [15:0] w;
      logic [2:0]  ch;
      do_reset();
      for (int k = 0; k < 8; k++) analog_in[12*k +: 12] = 12'h100 * k + k;
      for (int k = 0; k < 9; k++) begin
         ch = 3'(k);
         applyStimulus({2'b11, ch, 11'h5A5}, 16, 0, w);
         total++; if (w !== exp_resp[k]) begin bad++; $display("[TB] FAIL b2b_resp[%0d] got=%0h exp=%0h", k, w, exp_resp[k]); end
         total++; if (cmd_chnnl !== ch) begin bad++; $display("[TB] FAIL b2b_chnnl[%0d] got=%0h exp=%0h", k, cmd_chnnl, ch); end
         if (k == 7) begin
            total++; if (xfer_cnt !== 16'd8) begin bad++; $display("[TB] FAIL b2b_xfer got=%0h exp=8", xfer_cnt); end
         end
      end
   endtask

   task automatic test_snapshot();
      logic [15:0] w;
      analog_in[71:60] = 12'h123;
      applyStimulus(16'h2800, 16, 0, w);
      analog_in[71:60] = 12'hFFF;
      applyStimulus(16'h2800, 16, 0, w);
      total++; if (w !== 16'h0123) begin bad++; $display("[TB] FAIL snap_old got=%0h exp=0123", w); end
      applyStimulus(16'h0000, 16, 0, w);
      total++; if (w !== 16'h0FFF) begin bad++; $display("[TB] FAIL snap_new got=%0h exp=0fff", w); end
   endtask

   task automatic test_short_frame();
      logic [15:0] w;
      logic [15:0] x0;
      int v0;
      analog_in[35:24] = 12'h222;
      applyStimulus(16'h1000, 16, 0, w);
      x0 = xfer_cnt;
      v0 = vld_cnt;
      applyStimulus(16'h3000, 12, 0, w);
      total++; if (vld_cnt != v0) begin bad++; $display("[TB] FAIL short_vld got=%0d exp=0", vld_cnt - v0); end
      total++; if (cmd_chnnl !== 3'd2) begin bad++; $display("[TB] FAIL short_chnnl got=%0h exp=2", cmd_chnnl); end
      total++; if (xfer_cnt !== x0) begin bad++; $display("[TB] FAIL short_xfer got=%0h exp=%0h", xfer_cnt, x0); end
`ifdef A2D_RESP_FRMERR_EN
      total++; if (frm_err !== 1'b1) begin bad++; $display("[TB] FAIL short_frmerr got=%0h exp=1", frm_err); end
`endif
      applyStimulus(16'h0000, 16, 0, w);
      total++; if (w !== 16'h0222) begin bad++; $display("[TB] FAIL short_result_kept got=%0h exp=0222", w); end
   endtask

   task automatic test_mid_frame_reset();
      logic [15:0] w;
      int v0;
      applyStimulus(16'h0800, 16, 0, w);
      v0 = vld_cnt;
      applyStimulus(16'h2000, 16, 8, w);
      total++; if (snap_rst_busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%0h exp=0", snap_rst_busy); end
      total++; if (snap_rst_miso !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_miso got=%0h exp=0", snap_rst_miso); end
      total++; if (snap_rst_vld !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_vld got=%0h exp=0", snap_rst_vld); end
      total++; if (snap_rst_chnnl !== 3'd0) begin bad++; $display("[TB] FAIL rstmid_chnnl got=%0h exp=0", snap_rst_chnnl); end
      total++; if (snap_rst_xfer !== 16'd0) begin bad++; $display("[TB] FAIL rstmid_xfer got=%0h exp=0", snap_rst_xfer); end
      total++; if (snap_busy_end !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy_end got=%0h exp=0", snap_busy_end); end
      total++; if (vld_cnt != v0) begin bad++; $display("[TB] FAIL rstmid_no_vld got=%0d exp=0", vld_cnt - v0); end
`ifdef A2D_RESP_FRMERR_EN
      total++; if (frm_err !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_frmerr got=%0h exp=0", frm_err); end
`endif
      analog_in[59:48] = 12'h444;
      v0 = vld_cnt;
      applyStimulus(16'h2000, 16, 0, w);
      total++; if (w !== 16'h0000) begin bad++; $display("[TB] FAIL rstmid_resp got=%0h exp=0000", w); end
      total++; if (vld_cnt - v0 != 1) begin bad++; $display("[TB] FAIL rstmid_next_vld got=%0d exp=1", vld_cnt - v0); end
      total++; if (cmd_chnnl !== 3'd4) begin bad++; $display("[TB] FAIL rstmid_next_chnnl got=%0h exp=4", cmd_chnnl); end
      total++; if (xfer_cnt !== 16'd1) begin bad++; $display("[TB] FAIL rstmid_next_xfer got=%0h exp=1", xfer_cnt); end
      applyStimulus(16'h0000, 16, 0, w);
      total++; if (w !== 16'h0444) begin bad++; $display("[TB] FAIL rstmid_next_resp got=%0h exp=0444", w); end
   endtask

   task automatic test_xfer_wrap();
      logic [15:0] w;
      int v0;
      @(negedge clk);
      force dut.xfer_cnt_q = 16'hFFFF;
      repeat (3) @(negedge clk);
      release dut.xfer_cnt_q;
      repeat (2) @(negedge clk);
      total++; if (xfer_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL wrap_preload got=%0h exp=ffff", xfer_cnt); end
      v0 = vld_cnt;
      applyStimulus(16'h0800, 16, 0, w);
      total++; if (xfer_cnt !== 16'h0000) begin bad++; $display("[TB] FAIL wrap_xfer got=%0h exp=0000", xfer_cnt); end
      total++; if (vld_cnt - v0 != 1) begin bad++; $display("[TB] FAIL wrap_vld got=%0d exp=1", vld_cnt - v0); end
      total++; if (cmd_chnnl !== 3'd1) begin bad++; $display("[TB] FAIL wrap_chnnl got=%0h exp=1", cmd_chnnl); end
   endtask

   initial begin
      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; analog_in = '0;
      test_reset();
      test_good_frame();
      test_back_to_back();
      test_snapshot();
      test_short_frame();
      test_mid_frame_reset();
      test_xfer_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
